core_mem: RTL and testbench
===========================

CORE_MEM -- requirements
Module: core_MEM

Interface
REQ-001 SHALL have ports: clock  input  1  clock; reset is asynchronous, active-high; all flops rise-edge on clock.
REQ-002 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have port: EX_regs  input  EX_regs_t  execute-stage register bundle (out=address/result, B_data, W_regnum, write_enable, mem_load_type, mem_store_type, signed_byte, signed_word).
REQ-004 SHALL have port: flush  input  1  kill current MEM-stage instruction.
REQ-005 SHALL have ports: dmem_req_valid  output  1  request valid; dmem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have ports: dmem_addr  output  64  doubleword-aligned address; dmem_we  output  1  store; dmem_wdata  output  64; dmem_wmask  output  8  byte-lane enables.
REQ-007 SHALL have ports: dmem_rvalid  input  1  load data valid; dmem_rdata  input  64.
REQ-008 SHALL have ports: stall  output  1  hold upstream stages; addr_error  output  1  registered misaligned-access flag.
REQ-009 SHALL have ports: MEM_W_data  output  64; MEM_W_regnum  output  5; MEM_write_enable  output  1; MEM_data  output  64  forwarding copy of MEM_W_data.

Function
REQ-010 SHALL decode mem_load_type/mem_store_type (2 bits): 0 none, 1 byte, 2 word (32b), 3 doubleword.
REQ-011 SHALL treat an access as misaligned when word and address[1:0]!=0, or doubleword and address[2:0]!=0; bytes never misaligned.
REQ-012 SHALL drive dmem_addr = {EX_regs.out[63:3], 3'b000}.
REQ-013 SHALL implement FSM states IDLE, WAIT_RESP, DRAIN.
REQ-014 IDLE, aligned mem op, no flush: SHALL assert dmem_req_valid combinationally and stall=1 until completion.
REQ-015 Store accepted (valid&ready) in IDLE: SHALL complete that cycle (stall=0), stay IDLE, MEM_write_enable=0 next cycle.
REQ-016 Load accepted in IDLE: SHALL go to WAIT_RESP; if dmem_rvalid in same cycle as accept, SHALL complete immediately and stay IDLE.
REQ-017 WAIT_RESP: dmem_req_valid=0, stall=1; on dmem_rvalid SHALL complete (stall=0), register extracted data, return to IDLE.
REQ-018 Store data: byte -> B_data[7:0] replicated 8x, mask 1<<addr[2:0]; word -> {2{B_data[31:0]}}, mask 8'h0F<<(4*addr[2]); doubleword -> B_data, mask 8'hFF.
REQ-019 Load data: byte lane addr[2:0], sign-extended iff signed_byte else zero-extended; word lane addr[2], sign-extended iff signed_word; doubleword unchanged.
REQ-020 Non-memory instruction: SHALL pass EX_regs.out/W_regnum/write_enable to MEM outputs in one cycle, stall=0, no request.
REQ-021 Misaligned access: SHALL issue no request, stall=0, register addr_error=1 and MEM_write_enable=0 for one cycle.
REQ-022 MEM outputs SHALL update only on a completion cycle (stall=0); while stall=1 they SHALL hold MEM_write_enable=0.
REQ-023 flush in IDLE: SHALL suppress dmem_req_valid, register MEM outputs and addr_error as 0, stall=0.
REQ-024 flush in WAIT_RESP: SHALL go to DRAIN (or IDLE if dmem_rvalid same cycle), discard response, MEM_write_enable=0.
REQ-025 DRAIN: stall=1, dmem_req_valid=0; on dmem_rvalid SHALL return to IDLE discarding data.
REQ-026 MEM_data SHALL equal MEM_W_data at all times.

Reset
REQ-027 reset SHALL force state IDLE and MEM_W_data, MEM_W_regnum, MEM_write_enable, addr_error to 0 immediately, without clock.
REQ-028 During reset dmem_req_valid and stall SHALL be 0; reset in WAIT_RESP/DRAIN SHALL abandon the transaction and ignore later rvalid.

Verification
REQ-029 ALU op out=0x1234, W_regnum=5, we=1 -> next cycle MEM_W_data=0x1234, MEM_W_regnum=5, MEM_write_enable=1, stall never 1.
REQ-030 Signed byte load addr 0x1003, ready=1, rvalid 3 cycles later with rdata lane3=0x80 -> stall=1 for 4 cycles, MEM_W_data=0xFFFFFFFFFFFFFF80.
REQ-031 Word store addr 0x2004, B_data=0xDEADBEEF, ready held 0 for 2 cycles -> req_valid 3 cycles, wmask=0xF0, wdata=0xDEADBEEFDEADBEEF, stall drops on accept.
REQ-032 Doubleword load addr 0x3004 -> no request, addr_error=1 one cycle, MEM_write_enable=0, stall=0.
REQ-033 Load accepted, flush next cycle, rvalid 2 cycles later -> DRAIN, stall=1 until rvalid, MEM_write_enable stays 0, IDLE after.
REQ-034 Reset asserted in WAIT_RESP -> outputs 0 asynchronously; later stray rvalid produces no write.

Source files
------------

// File: rtl/core_mem.sv
`default_nettype none
// ============================================================================
// Module      : core_mem (with core_mem_pkg)
// Description : Memory stage of the pipeline. Issues data-memory requests with
//               a valid/ready handshake and waits for the load response
//               (rvalid). Places store data on byte lanes and extracts and
//               sign-extends load data. Stalls upstream while an access is in
//               flight and drains responses to flushed loads.
// Revision    : 1.0 - initial release
// ============================================================================

package core_mem_pkg;

    // Execute-stage register bundle handed to the memory stage.
    typedef struct packed {
        logic [63:0] out;             // ALU result / effective address
        logic [63:0] B_data;          // store data
        logic [4:0]  W_regnum;        // destination register
        logic        write_enable;    // register write-back enable
        logic [1:0]  mem_load_type;   // 0 none, 1 byte, 2 word, 3 doubleword
        logic [1:0]  mem_store_type;  // 0 none, 1 byte, 2 word, 3 doubleword
        logic        signed_byte;     // sign-extend byte loads
        logic        signed_word;     // sign-extend word loads
    } EX_regs_t;

endpackage

module core_mem (
    input  logic                   clock,
    input  logic                   reset,
    input  core_mem_pkg::EX_regs_t EX_regs,
    input  logic                   flush,
    output logic                   dmem_req_valid,
    input  logic                   dmem_req_ready,
    output logic [63:0]            dmem_addr,
    output logic                   dmem_we,
    output logic [63:0]            dmem_wdata,
    output logic [7:0]             dmem_wmask,
    input  logic                   dmem_rvalid,
    input  logic [63:0]            dmem_rdata,
    output logic                   stall,
    output logic                   addr_error,
    output logic [63:0]            MEM_W_data,
    output logic [4:0]             MEM_W_regnum,
    output logic                   MEM_write_enable,
    output logic [63:0]            MEM_data
);

    localparam logic [1:0] c_SZ_NONE = 2'd0;
    localparam logic [1:0] c_SZ_BYTE = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;
    localparam logic [1:0] c_SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_DRAIN     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Load attributes captured at request acceptance so the response is
    // formatted correctly whatever the upstream stages present meanwhile.
    logic [2:0]  r_pend_off;
    logic [1:0]  r_pend_size;
    logic        r_pend_sb;
    logic        r_pend_sw;
    logic [4:0]  r_pend_regnum;
    logic        r_pend_we;

    logic [63:0] r_mem_w_data;
    logic [4:0]  r_mem_w_regnum;
    logic        r_mem_we;
    logic        r_addr_error;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_size;
    logic        w_misaligned;

    logic        w_complete;
    logic        w_latch_load;
    logic [63:0] w_cmp_data;
    logic [4:0]  w_cmp_regnum;
    logic        w_cmp_we;
    logic        w_cmp_err;

    // Pick the byte or word lane out of a doubleword and extend it.
    function automatic logic [63:0] f_extract(
        input logic [63:0] data,
        input logic [2:0]  off,
        input logic [1:0]  size,
        input logic        sb,
        input logic        sw
    );
        logic [7:0]  v_byte;
        logic [31:0] v_word;
        logic [63:0] v_res;
        v_byte = data[{off, 3'b000} +: 8];
        v_word = off[2] ? data[63:32] : data[31:0];
        case (size)
            c_SZ_BYTE: v_res = sb ? {{56{v_byte[7]}}, v_byte} : {56'd0, v_byte};
            c_SZ_WORD: v_res = sw ? {{32{v_word[31]}}, v_word} : {32'd0, v_word};
            default:   v_res = data;
        endcase
        return v_res;
    endfunction

    // A load takes precedence if both type fields are (illegally) non-zero.
    assign w_is_load  = (EX_regs.mem_load_type != c_SZ_NONE);
    assign w_is_store = !w_is_load && (EX_regs.mem_store_type != c_SZ_NONE);
    assign w_size     = w_is_load ? EX_regs.mem_load_type : EX_regs.mem_store_type;

    assign w_misaligned = ((w_size == c_SZ_WORD)  && (EX_regs.out[1:0] != 2'b00)) ||
                          ((w_size == c_SZ_DWORD) && (EX_regs.out[2:0] != 3'b000));

    assign dmem_addr = {EX_regs.out[63:3], 3'b000};

    // Store lane placement: replicate the datum and enable only its lanes.
    always_comb begin
        dmem_we    = w_is_store;
        dmem_wdata = 64'd0;
        dmem_wmask = 8'h00;
        if (w_is_store) begin
            case (w_size)
                c_SZ_BYTE: begin
                    dmem_wdata = {8{EX_regs.B_data[7:0]}};
                    dmem_wmask = 8'h01 << EX_regs.out[2:0];
                end
                c_SZ_WORD: begin
                    dmem_wdata = {2{EX_regs.B_data[31:0]}};
                    dmem_wmask = 8'h0F << {EX_regs.out[2], 2'b00};
                end
                default: begin
                    dmem_wdata = EX_regs.B_data;
                    dmem_wmask = 8'hFF;
                end
            endcase
        end
    end

    // State register; reset abandons any outstanding transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, handshake, stall and completion values.
    always_comb begin
        w_state_next   = r_state;
        dmem_req_valid = 1'b0;
        stall          = 1'b0;
        w_complete     = 1'b0;
        w_latch_load   = 1'b0;
        w_cmp_data     = 64'd0;
        w_cmp_regnum   = 5'd0;
        w_cmp_we       = 1'b0;
        w_cmp_err      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        // Killed instruction retires as a bubble.
                        w_complete = 1'b1;
                    end else if (!w_is_load && !w_is_store) begin
                        w_complete   = 1'b1;
                        w_cmp_data   = EX_regs.out;
                        w_cmp_regnum = EX_regs.W_regnum;
                        w_cmp_we     = EX_regs.write_enable;
                    end else if (w_misaligned) begin
                        w_complete   = 1'b1;
                        w_cmp_data   = EX_regs.out;
                        w_cmp_regnum = EX_regs.W_regnum;
                        w_cmp_err    = 1'b1;
                    end else begin
                        dmem_req_valid = 1'b1;
                        if (!dmem_req_ready) begin
                            stall = 1'b1;
                        end else if (w_is_store) begin
                            w_complete   = 1'b1;
                            w_cmp_data   = EX_regs.out;
                            w_cmp_regnum = EX_regs.W_regnum;
                        end else if (dmem_rvalid) begin
                            // Zero-latency response: finish in the accept cycle.
                            w_complete   = 1'b1;
                            w_cmp_data   = f_extract(dmem_rdata, EX_regs.out[2:0], w_size,
                                                     EX_regs.signed_byte, EX_regs.signed_word);
                            w_cmp_regnum = EX_regs.W_regnum;
                            w_cmp_we     = EX_regs.write_enable;
                        end else begin
                            stall        = 1'b1;
                            w_latch_load = 1'b1;
                            w_state_next = S_WAIT_RESP;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (flush) begin
                        if (dmem_rvalid) begin
                            w_complete   = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            stall        = 1'b1;
                            w_state_next = S_DRAIN;
                        end
                    end else if (dmem_rvalid) begin
                        w_complete   = 1'b1;
                        w_cmp_data   = f_extract(dmem_rdata, r_pend_off, r_pend_size,
                                                 r_pend_sb, r_pend_sw);
                        w_cmp_regnum = r_pend_regnum;
                        w_cmp_we     = r_pend_we;
                        w_state_next = S_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Hold upstream through the discarded response so the
                    // instruction waiting in EX is seen from IDLE next cycle.
                    stall = 1'b1;
                    if (dmem_rvalid) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Capture load attributes when a load is accepted without a response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_off    <= 3'd0;
            r_pend_size   <= c_SZ_NONE;
            r_pend_sb     <= 1'b0;
            r_pend_sw     <= 1'b0;
            r_pend_regnum <= 5'd0;
            r_pend_we     <= 1'b0;
        end else if (w_latch_load) begin
            r_pend_off    <= EX_regs.out[2:0];
            r_pend_size   <= w_size;
            r_pend_sb     <= EX_regs.signed_byte;
            r_pend_sw     <= EX_regs.signed_word;
            r_pend_regnum <= EX_regs.W_regnum;
            r_pend_we     <= EX_regs.write_enable;
        end
    end

    // MEM result registers: load on completion, otherwise hold as a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_w_data   <= 64'd0;
            r_mem_w_regnum <= 5'd0;
            r_mem_we       <= 1'b0;
            r_addr_error   <= 1'b0;
        end else if (w_complete) begin
            r_mem_w_data   <= w_cmp_data;
            r_mem_w_regnum <= w_cmp_regnum;
            r_mem_we       <= w_cmp_we;
            r_addr_error   <= w_cmp_err;
        end else begin
            r_mem_we       <= 1'b0;
            r_addr_error   <= 1'b0;
        end
    end

    assign MEM_W_data       = r_mem_w_data;
    assign MEM_data         = r_mem_w_data;
    assign MEM_W_regnum     = r_mem_w_regnum;
    assign MEM_write_enable = r_mem_we;
    assign addr_error       = r_addr_error;

endmodule

`default_nettype wire

// File: tb/tb_core_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem
// Description : Directed vector bench for core_mem: single-cycle table plus
//               multi-cycle handshake, flush/drain and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem;

    logic                   clock = 1'b0;
    logic                   reset;
    core_mem_pkg::EX_regs_t ex;
    logic                   flush;
    logic                   dmem_req_valid;
    logic                   dmem_req_ready;
    logic [63:0]            dmem_addr;
    logic                   dmem_we;
    logic [63:0]            dmem_wdata;
    logic [7:0]             dmem_wmask;
    logic                   dmem_rvalid;
    logic [63:0]            dmem_rdata;
    logic                   stall;
    logic                   addr_error;
    logic [63:0]            MEM_W_data;
    logic [4:0]             MEM_W_regnum;
    logic                   MEM_write_enable;
    logic [63:0]            MEM_data;

    core_mem dut (
        .clock            (clock),
        .reset            (reset),
        .EX_regs          (ex),
        .flush            (flush),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_addr        (dmem_addr),
        .dmem_we          (dmem_we),
        .dmem_wdata       (dmem_wdata),
        .dmem_wmask       (dmem_wmask),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .addr_error       (addr_error),
        .MEM_W_data       (MEM_W_data),
        .MEM_W_regnum     (MEM_W_regnum),
        .MEM_write_enable (MEM_write_enable),
        .MEM_data         (MEM_data)
    );

    always #5 clock = ~clock;

    localparam logic [63:0] RD = 64'hF122_3344_0899_AABB;

    typedef struct packed {
        logic [63:0] out;
        logic [63:0] bdata;
        logic [4:0]  regnum;
        logic        we;
        logic [1:0]  lt;
        logic [1:0]  st;
        logic        sb;
        logic        sw;
        logic        fl;
        logic        rdy;
        logic        rv;
        logic [63:0] rdata;
        logic        e_req;
        logic        e_dwe;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic        e_stall;
        logic        chk_d;
        logic [63:0] e_data;
        logic [4:0]  e_regnum;
        logic        e_we;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_ex(input logic [63:0] out, input logic [63:0] bdata, input logic [4:0] rn,
                          input logic we, input logic [1:0] lt, input logic [1:0] st,
                          input logic sb, input logic sw);
        ex.out            = out;
        ex.B_data         = bdata;
        ex.W_regnum       = rn;
        ex.write_enable   = we;
        ex.mem_load_type  = lt;
        ex.mem_store_type = st;
        ex.signed_byte    = sb;
        ex.signed_word    = sw;
    endtask

    task automatic set_nop();
        set_ex(64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        flush          = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rvalid    = 1'b0;
        dmem_rdata     = 64'd0;
    endtask

    int cnt;

    initial begin
        // out, bdata, rn, we, lt, st, sb, sw, fl, rdy, rv, rdata,
        // e_req, e_dwe, e_wdata, e_wmask, e_stall, chk_d, e_data, e_regnum, e_we, e_err
        vecs.push_back('{64'h1234, 64'h0, 5'd5, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h1234, 5'd5, 1'b1, 1'b0});
        vecs.push_back('{64'h1005, 64'h55AB, 5'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b1, 1'b1, 64'hABAB_ABAB_ABAB_ABAB, 8'h20, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{64'h2004, 64'hDEAD_BEEF, 5'd0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{64'h4000, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{64'h10, 64'h0, 5'd7, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0000_0000_0899_AABB, 5'd7, 1'b1, 1'b0});
        vecs.push_back('{64'h14, 64'h0, 5'd8, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_F122_3344, 5'd8, 1'b1, 1'b0});
        vecs.push_back('{64'h6, 64'h0, 5'd9, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h22, 5'd9, 1'b1, 1'b0});
        vecs.push_back('{64'h2, 64'h0, 5'd10, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF99, 5'd10, 1'b1, 1'b0});
        vecs.push_back('{64'h7, 64'h0, 5'd11, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'hF1, 5'd11, 1'b1, 1'b0});
        vecs.push_back('{64'h28, 64'h0, 5'd12, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, RD, 5'd12, 1'b1, 1'b0});
        vecs.push_back('{64'h3004, 64'h0, 5'd3, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1});
        vecs.push_back('{64'h2002, 64'h1, 5'd0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,
                         1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1});
        vecs.push_back('{64'h1003, 64'h0, 5'd13, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, RD,
                         1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h08, 5'd13, 1'b1, 1'b0});
        vecs.push_back('{64'h40, 64'h0, 5'd14, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, RD,
                         1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{64'h50, 64'h77, 5'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,
                         1'b1, 1'b1, 64'h77, 8'hFF, 1'b1, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{64'hABC, 64'h0, 5'd2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,
                         1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'hABC, 5'd2, 1'b0, 1'b0});

        // Reset state, checked without any clock edge having occurred.
        set_nop();
        reset = 1'b1;
        #2;
        chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_we", 64'(MEM_write_enable), 64'd0);
        chk("rst_wdata", MEM_W_data, 64'd0);
        chk("rst_err", 64'(addr_error), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single-cycle table.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clock);
            set_ex(vecs[i].out, vecs[i].bdata, vecs[i].regnum, vecs[i].we,
                   vecs[i].lt, vecs[i].st, vecs[i].sb, vecs[i].sw);
            flush          = vecs[i].fl;
            dmem_req_ready = vecs[i].rdy;
            dmem_rvalid    = vecs[i].rv;
            dmem_rdata     = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req_valid", i), 64'(dmem_req_valid), 64'(vecs[i].e_req));
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].out & ~64'h7);
            if (vecs[i].e_req) chk($sformatf("v%0d_dmem_we", i), 64'(dmem_we), 64'(vecs[i].e_dwe));
            if (vecs[i].e_req && vecs[i].e_dwe) begin
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d_wmask", i), 64'(dmem_wmask), 64'(vecs[i].e_wmask));
            end
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_mem_we", i), 64'(MEM_write_enable), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_addr_error", i), 64'(addr_error), 64'(vecs[i].e_err));
            chk($sformatf("v%0d_mem_data_fwd", i), MEM_data, MEM_W_data);
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d_mem_w_data", i), MEM_W_data, vecs[i].e_data);
                chk($sformatf("v%0d_mem_regnum", i), 64'(MEM_W_regnum), 64'(vecs[i].e_regnum));
            end
        end

        // Signed byte load with a 3-cycle-late response: 4 stall cycles.
        @(negedge clock);
        set_nop();
        set_ex(64'h1003, 64'h0, 5'd4, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0);
        dmem_req_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) begin
                @(negedge clock);
                dmem_req_ready = 1'b0;
            end
            dmem_rvalid = (c == 4);
            dmem_rdata  = (c == 4) ? 64'h0000_0000_8000_0000 : 64'd0;
            #1;
            if (stall) cnt++;
            @(posedge clock);
            #1;
            if (c < 4) chk($sformatf("ld_wait%0d_mem_we", c), 64'(MEM_write_enable), 64'd0);
        end
        chk("ld_stall_cycles", 64'(cnt), 64'd4);
        chk("ld_mem_w_data", MEM_W_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("ld_mem_we", 64'(MEM_write_enable), 64'd1);
        chk("ld_mem_regnum", 64'(MEM_W_regnum), 64'd4);

        // Word store held off by ready for two cycles.
        @(negedge clock);
        set_nop();
        set_ex(64'h2004, 64'hDEAD_BEEF, 5'd0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clock);
            dmem_req_ready = (c == 2);
            #1;
            if (dmem_req_valid) cnt++;
            chk($sformatf("st%0d_stall", c), 64'(stall), (c == 2) ? 64'd0 : 64'd1);
            chk($sformatf("st%0d_wmask", c), 64'(dmem_wmask), 64'hF0);
            chk($sformatf("st%0d_wdata", c), dmem_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
            @(posedge clock);
        end
        chk("st_req_cycles", 64'(cnt), 64'd3);
        #1;
        chk("st_mem_we", 64'(MEM_write_enable), 64'd0);

        // Load accepted, flushed while waiting, response drained.
        @(negedge clock);
        set_nop();
        set_ex(64'h38, 64'h0, 5'd9, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
        dmem_req_ready = 1'b1;
        #1;
        chk("fl_accept_stall", 64'(stall), 64'd1);
        for (int c = 1; c < 4; c++) begin
            @(negedge clock);
            dmem_req_ready = 1'b0;
            flush          = (c == 1);
            dmem_rvalid    = (c == 3);
            dmem_rdata     = RD;
            #1;
            chk($sformatf("fl%0d_stall", c), 64'(stall), 64'd1);
            chk($sformatf("fl%0d_req_valid", c), 64'(dmem_req_valid), 64'd0);
            @(posedge clock);
            #1;
            chk($sformatf("fl%0d_mem_we", c), 64'(MEM_write_enable), 64'd0);
        end
        @(negedge clock);
        set_nop();
        set_ex(64'h99, 64'h0, 5'd6, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        #1;
        chk("fl_after_stall", 64'(stall), 64'd0);
        @(posedge clock);
        #1;
        chk("fl_after_mem_we", 64'(MEM_write_enable), 64'd1);
        chk("fl_after_data", MEM_W_data, 64'h99);

        // Reset while a load is outstanding, then a stray response.
        @(negedge clock);
        set_nop();
        set_ex(64'h60, 64'h0, 5'd17, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
        dmem_req_ready = 1'b1;
        @(negedge clock);
        dmem_req_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("ar_mem_w_data", MEM_W_data, 64'd0);
        chk("ar_mem_we", 64'(MEM_write_enable), 64'd0);
        chk("ar_stall", 64'(stall), 64'd0);
        chk("ar_req_valid", 64'(dmem_req_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        set_nop();
        dmem_rvalid = 1'b1;
        dmem_rdata  = RD;
        #1;
        chk("ar_stray_stall", 64'(stall), 64'd0);
        @(posedge clock);
        #1;
        chk("ar_stray_mem_we", 64'(MEM_write_enable), 64'd0);
        chk("ar_stray_regnum", 64'(MEM_W_regnum), 64'd0);
        @(negedge clock);
        set_nop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
